// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// instruction-fetch and data ports, alternating priority under contention,
// with a stall output and a sticky memory timeout error.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clk_en,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        err_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_ERROR} state_t;

  // The counter holds the number of WAIT cycles already completed, so the
  // error trips on the edge that ends WAIT cycle number TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic          last_dm_q;
  logic          owner_dm_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [1:0]    mem_size_q;
  logic [31:0]   if_rdata_q, dm_rdata_q;
  logic          if_valid_q, dm_valid_q;
  logic          err_q;

  logic dm_req;
  logic any_req;
  logic grant_dm_d;
  logic stall_d;

  assign dm_req  = dm_read | dm_write;
  assign any_req = if_en | dm_req;

  // Data wins when it is the only requester or when IF was granted last.
  assign grant_dm_d = dm_req & (~if_en | ~last_dm_q);

  // Stall: pending request in IDLE, always in WAIT/ERROR, and in RESP only
  // when the port that is not being answered is still waiting.
  always_comb begin
    stall_d = 1'b0;
    case (state_q)
      ST_IDLE: stall_d = any_req;
      ST_RESP: stall_d = owner_dm_q ? if_en : dm_req;
      default: stall_d = 1'b1;
    endcase
  end

  // Arbitration FSM with all memory-side and response outputs registered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      last_dm_q   <= 1'b0;
      owner_dm_q  <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (clk_en) begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_dm_q <= grant_dm_d;
            last_dm_q  <= grant_dm_d;
            mem_req_q  <= 1'b1;
            cnt_q      <= '0;
            if (grant_dm_d) begin
              mem_we_q    <= dm_write;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
              mem_size_q  <= dm_size;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_size_q  <= 2'b10;
            end
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (owner_dm_q) begin
              dm_rdata_q <= mem_we_q ? 32'h0 : mem_rdata;
              dm_valid_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_valid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign dm_rdata    = dm_rdata_q;
  assign dm_valid    = dm_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_size    = mem_size_q;
  assign stall       = stall_d;
  assign err_timeout = err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the CPU's instruction-fetch port and its data load/store port. It sits between the CPU core and the unified memory macro. It serialises requests with alternating priority under contention and registers read data back to the winner. It also holds off the core with a `stall` output and flags a hung memory with a sticky timeout error.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles in WAIT without `mem_ack` before the error trips. Legal range 1..255.
- `CW`, 8: width of the timeout counter.

Ports:
- `clk` in 1: core clock.
- `nreset` in 1: asynchronous, active-low reset.
- `clk_en` in 1: clock enable. When 0, all state and outputs hold.
- `if_en` in 1: instruction fetch request. Level; held until `if_valid`.
- `if_addr` in 32: fetch byte address. Always a word access.
- `if_rdata` out 32: fetched word. Valid while `if_valid`=1.
- `if_valid` out 1: one-cycle completion pulse for a fetch.
- `dm_read` in 1: data read request. Level; held until `dm_valid`.
- `dm_write` in 1: data write request. Level. Takes precedence over `dm_read` if both are 1.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: write data.
- `dm_size` in 2: access size, passed through unchanged.
- `dm_rdata` out 32: read data. Valid while `dm_valid`=1. Value is 0 for writes.
- `dm_valid` out 1: one-cycle completion pulse for a data access.
- `mem_req` out 1: memory request. Held until `mem_ack`.
- `mem_we` out 1: write strobe, qualified by `mem_req`.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_size` out 2: memory access size.
- `mem_ack` in 1: memory completion. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read data.
- `stall` out 1: high whenever any request is pending and not yet completed.
- `err_timeout` out 1: sticky memory-timeout error.

## Operation
- State machine with states IDLE, WAIT, RESP and ERROR. Reset state is IDLE.
- `last_dm` flag: 1 means the most recent grant went to the data port. Reset value is 0.
- In IDLE, a request is pending if `if_en`=1 or (`dm_read`|`dm_write`)=1.
  - Only one requester pending: grant to it.
  - Both pending: grant to the data port if `last_dm`=0, otherwise to IF. Strict alternation.
- On grant:
  - Latch the owner, address, write data, `we` and size into output registers.
  - Update `last_dm`.
  - Set `mem_req`=1 and go to WAIT.
  - IF grants force `mem_we`=0 and `mem_size`=2'b10.
- WAIT:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_size` are held constant.
  - The counter increments every enabled cycle.
  - On `mem_ack`: capture `mem_rdata` (forced to 0 for writes) into the owner's rdata register, drop `mem_req`, clear the counter and go to RESP.
  - If the counter reaches `TIMEOUT` with no `mem_ack`: drop `mem_req`, set `err_timeout`=1 and go to ERROR.
- RESP:
  - The owner's valid output is 1 for exactly this cycle. Unconditional return to IDLE.
  - No arbitration occurs in RESP. The requester changes or drops its request on the edge that ends RESP.
- ERROR is absorbing until `nreset`. `stall`=1, no memory requests are issued, and no valid pulses are produced.
- `stall` = (request pending in IDLE) | WAIT | ERROR. In RESP it is 0 only if no other request is present.
- Request inputs that change while that requester is in WAIT have no effect on the issued transaction.
- An `mem_ack` seen outside WAIT is ignored.

## Timing
- Reset values (asynchronous): all outputs 0, including `if_rdata`, `dm_rdata` and `err_timeout`. Counter 0, `last_dm`=0.
- Reset asserted mid-transaction: the transfer is abandoned immediately, `mem_req` goes to 0 asynchronously, and no valid pulse is produced after release.
- With `clk_en`=0 nothing advances. The counter does not count and any `mem_ack` arriving that cycle is ignored; memory must hold `mem_ack` until an enabled edge.
- Latency for a zero-wait memory (ack in the first WAIT cycle):
  - Request seen at edge 0.
  - `mem_req` is high during cycle 1.
  - Valid is high during cycle 2.
  - IDLE in cycle 3.
  - Each additional memory wait cycle adds 1.
- Throughput: one access per 3 cycles minimum. Under contention, IF and data alternate one access each.

## Test plan
- Single fetch, zero-wait memory. `if_en`=1, `if_addr`=0x10, memory returns 0xDEADBEEF with ack in the first WAIT cycle. Required: `mem_req` for 1 cycle with `mem_we`=0, `mem_size`=2; `if_valid` pulses 2 cycles after the request with `if_rdata`=0xDEADBEEF; `dm_valid` stays 0.
- Contention alternation. Hold `if_en`, `dm_read` and `dm_write` all 1 from reset. Required grant order: DM, IF, DM, IF. Every DM access has `mem_we`=1 because write has precedence. Exactly one valid pulse per 3 cycles.
- Data write. `dm_write`=1, `dm_addr`=0x400, `dm_wdata`=0x12345678, `dm_size`=0, memory acks after 4 wait cycles. Required: `mem_*` stable for 5 cycles, `dm_valid` pulses once, `dm_rdata`=0.
- Timeout. `TIMEOUT`=8 and memory never acks. Required: `mem_req` drops after 8 WAIT cycles; `err_timeout` and `stall` stay 1 permanently; later requests produce no `mem_req`. Asserting `nreset` clears everything.
- Reset and clock-enable boundary.
  - Assert `nreset`=0 in the middle of WAIT. Required: `mem_req`=0 immediately, and no `if_valid` or `dm_valid` after release.
  - Separately, hold `clk_en`=0 for 3 cycles during WAIT while `mem_ack`=1, then raise `clk_en`. Required: completion occurs only on the first enabled edge.
